mem_stage: RTL and testbench

- Memory-access stage of the 5-stage RV32I core, directly downstream of the EX stage.
- Contains the EX/MEM pipeline register and a load/store FSM with a req/gnt/rvalid data-memory handshake. It also performs byte/halfword alignment and the MEM/WB pipeline register.
- Stalls upstream while a memory transaction is outstanding.
- Exports the MEM-stage forwarding values: ALU result and aligned load data.

---
 rtl/mem_stage.sv | 213 +++++++++++++++++++++
 tb/tb_mem_stage.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: EX/MEM slot, load/store handshake FSM,
// byte/halfword alignment and the MEM/WB register.
module mem_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ex_valid_i,
  input  logic [DATA_WIDTH-1:0]     ex_alu_result_i,
  input  logic [DATA_WIDTH-1:0]     ex_rd_data2_i,
  input  logic [2:0]                ex_funct3_i,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr_i,
  input  logic [DATA_WIDTH-1:0]     ex_pc_plus4_i,
  input  logic                      ex_RegWrite_i,
  input  logic                      ex_MemRead_i,
  input  logic                      ex_MemWrite_i,
  input  logic [1:0]                ex_WBSel_i,
  output logic                      dmem_req_o,
  output logic                      dmem_we_o,
  output logic [DATA_WIDTH-1:0]     dmem_addr_o,
  output logic [DATA_WIDTH-1:0]     dmem_wdata_o,
  output logic [3:0]                dmem_be_o,
  input  logic                      dmem_gnt_i,
  input  logic                      dmem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]     dmem_rdata_i,
  output logic                      stall_o,
  output logic [DATA_WIDTH-1:0]     alu_result_MEM_o,
  output logic [DATA_WIDTH-1:0]     mem_data_MEM_o,
  output logic                      wb_valid_o,
  output logic                      wb_RegWrite_o,
  output logic [DATA_WIDTH-1:0]     wb_alu_result_o,
  output logic [DATA_WIDTH-1:0]     wb_mem_data_o,
  output logic [DATA_WIDTH-1:0]     wb_pc_plus4_o,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd_addr_o,
  output logic [1:0]                wb_WBSel_o,
  output logic                      mem_fault_o
);

  localparam int DW = DATA_WIDTH;
  localparam int RW = REG_ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] alu;
    logic [DW-1:0] wdata;
    logic [DW-1:0] pc4;
    logic [2:0]    funct3;
    logic [RW-1:0] rd;
    logic          regwrite;
    logic          memread;
    logic          memwrite;
    logic [1:0]    wbsel;
  } slot_t;

  function automatic logic fault_f(
    input logic       rd,
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic bad;
    logic mis;
    if (rd)
      bad = !(f3 inside {3'b000, 3'b001, 3'b010,
                         3'b100, 3'b101});
    else
      bad = !(f3 inside {3'b000, 3'b001, 3'b010});
    mis = (f3[1:0] == 2'b01 && a[0]) ||
          (f3[1:0] == 2'b10 && a != 2'b00);
    return bad || mis;
  endfunction

  state_t state, state_nx;
  slot_t  s;

  logic ex_mem_ok;
  logic s_mem;
  logic s_fault;
  logic is_load;
  logic is_store;
  logic [DW-1:0] lane;
  logic [DW-1:0] ld_fmt;

  assign ex_mem_ok = ex_valid_i &&
                     (ex_MemRead_i || ex_MemWrite_i) &&
                     !fault_f(ex_MemRead_i, ex_funct3_i,
                              ex_alu_result_i[1:0]);

  assign s_mem    = s.valid && (s.memread || s.memwrite);
  assign s_fault  = s_mem &&
                    fault_f(s.memread, s.funct3, s.alu[1:0]);
  assign is_load  = s.memread;
  assign is_store = s.memwrite && !s.memread;

  assign stall_o =
    (state == REQ && !(dmem_gnt_i && is_store)) ||
    (state == REQ && is_load) ||
    (state == WAIT && !dmem_rvalid_i);

  assign dmem_req_o  = (state == REQ);
  assign dmem_we_o   = is_store;
  assign dmem_addr_o = {s.alu[DW-1:2], 2'b00};

  assign alu_result_MEM_o = s.alu;

  // State register; reset abandons any outstanding access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state: a completing access may chain straight into REQ.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: state_nx = ex_mem_ok ? REQ : IDLE;
      REQ: begin
        if (dmem_gnt_i) begin
          if (is_load) state_nx = WAIT;
          else state_nx = ex_mem_ok ? REQ : IDLE;
        end
      end
      WAIT: begin
        if (dmem_rvalid_i)
          state_nx = ex_mem_ok ? REQ : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Store lane replication and byte enables.
  always_comb begin
    dmem_be_o    = 4'b1111;
    dmem_wdata_o = s.wdata;
    case (s.funct3[1:0])
      2'b00: begin
        dmem_be_o    = 4'b0001 << s.alu[1:0];
        dmem_wdata_o = {(DW/8){s.wdata[7:0]}};
      end
      2'b01: begin
        dmem_be_o    = 4'b0011 << {s.alu[1], 1'b0};
        dmem_wdata_o = {(DW/16){s.wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane select and sign/zero extension.
  always_comb begin
    lane   = dmem_rdata_i >> {s.alu[1:0], 3'b000};
    ld_fmt = lane;
    case (s.funct3)
      3'b000: ld_fmt = {{(DW-8){lane[7]}}, lane[7:0]};
      3'b001: ld_fmt = {{(DW-16){lane[15]}}, lane[15:0]};
      3'b100: ld_fmt = {{(DW-8){1'b0}}, lane[7:0]};
      3'b101: ld_fmt = {{(DW-16){1'b0}}, lane[15:0]};
      default: ld_fmt = lane;
    endcase
    mem_data_MEM_o = '0;
    if (state == WAIT && dmem_rvalid_i)
      mem_data_MEM_o = ld_fmt;
  end

  // EX/MEM slot, frozen while an access is outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s <= '0;
    end else if (!stall_o) begin
      s.valid    <= ex_valid_i;
      s.alu      <= ex_alu_result_i;
      s.wdata    <= ex_rd_data2_i;
      s.pc4      <= ex_pc_plus4_i;
      s.funct3   <= ex_funct3_i;
      s.rd       <= ex_rd_addr_i;
      s.regwrite <= ex_RegWrite_i;
      s.memread  <= ex_MemRead_i;
      s.memwrite <= ex_MemWrite_i;
      s.wbsel    <= ex_WBSel_i;
    end
  end

  // MEM/WB register; a stalled cycle hands WB a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_o      <= 1'b0;
      wb_RegWrite_o   <= 1'b0;
      mem_fault_o     <= 1'b0;
      wb_alu_result_o <= '0;
      wb_mem_data_o   <= '0;
      wb_pc_plus4_o   <= '0;
      wb_rd_addr_o    <= '0;
      wb_WBSel_o      <= '0;
    end else begin
      wb_alu_result_o <= s.alu;
      wb_mem_data_o   <= mem_data_MEM_o;
      wb_pc_plus4_o   <= s.pc4;
      wb_rd_addr_o    <= s.rd;
      wb_WBSel_o      <= s.wbsel;
      if (stall_o) begin
        wb_valid_o    <= 1'b0;
        wb_RegWrite_o <= 1'b0;
        mem_fault_o   <= 1'b0;
      end else begin
        wb_valid_o    <= s.valid;
        wb_RegWrite_o <= s.valid && s.regwrite && !s_fault;
        mem_fault_o   <= s_fault;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage.
// Hand-computed expectations per step.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [31:0] ex_alu;
  logic [31:0] ex_rs2;
  logic [2:0]  ex_f3;
  logic [4:0]  ex_rd;
  logic [31:0] ex_pc4;
  logic        ex_rw, ex_mr, ex_mw;
  logic [1:0]  ex_wbsel;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        gnt, rvalid;
  logic [31:0] rdata;
  logic        stall;
  logic [31:0] alu_mem, data_mem;
  logic        wb_valid, wb_rw;
  logic [31:0] wb_alu, wb_data, wb_pc4;
  logic [4:0]  wb_rd;
  logic [1:0]  wb_sel;
  logic        fault;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid_i(ex_valid),
    .ex_alu_result_i(ex_alu),
    .ex_rd_data2_i(ex_rs2),
    .ex_funct3_i(ex_f3),
    .ex_rd_addr_i(ex_rd),
    .ex_pc_plus4_i(ex_pc4),
    .ex_RegWrite_i(ex_rw),
    .ex_MemRead_i(ex_mr),
    .ex_MemWrite_i(ex_mw),
    .ex_WBSel_i(ex_wbsel),
    .dmem_req_o(req), .dmem_we_o(we),
    .dmem_addr_o(addr), .dmem_wdata_o(wdata),
    .dmem_be_o(be), .dmem_gnt_i(gnt),
    .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata),
    .stall_o(stall),
    .alu_result_MEM_o(alu_mem),
    .mem_data_MEM_o(data_mem),
    .wb_valid_o(wb_valid), .wb_RegWrite_o(wb_rw),
    .wb_alu_result_o(wb_alu),
    .wb_mem_data_o(wb_data),
    .wb_pc_plus4_o(wb_pc4),
    .wb_rd_addr_o(wb_rd), .wb_WBSel_o(wb_sel),
    .mem_fault_o(fault)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic bubble();
    ex_valid = 0; ex_alu = 0; ex_rs2 = 0;
    ex_f3 = 0; ex_rd = 0; ex_pc4 = 0;
    ex_rw = 0; ex_mr = 0; ex_mw = 0;
    ex_wbsel = 0;
  endtask

  task automatic set_load(input logic [2:0] f3,
                          input logic [31:0] a);
    bubble();
    ex_valid = 1; ex_alu = a; ex_f3 = f3;
    ex_mr = 1; ex_rw = 1; ex_rd = 7;
    ex_wbsel = 2'd1;
  endtask

  task automatic do_load(input string tag,
                         input logic [2:0] f3,
                         input logic [31:0] a,
                         input logic [31:0] rd_word,
                         input logic [31:0] exp,
                         input int extra);
    set_load(f3, a);
    gnt = 1;
    step();
    chk({tag, "_req"}, req, 1);
    chk({tag, "_stall_req"}, stall, 1);
    bubble();
    step();
    gnt = 0;
    chk({tag, "_wait_req"}, req, 0);
    chk({tag, "_wait_stall"}, stall, 1);
    chk({tag, "_wait_data0"}, data_mem, 0);
    for (int i = 0; i < extra; i++) begin
      step();
      chk({tag, "_stall_x"}, stall, 1);
    end
    rvalid = 1;
    rdata = rd_word;
    #1;
    chk({tag, "_done_stall"}, stall, 0);
    chk({tag, "_fwd"}, data_mem, exp);
    step();
    rvalid = 0;
    rdata = 0;
    chk({tag, "_wb_valid"}, wb_valid, 1);
    chk({tag, "_wb_rw"}, wb_rw, 1);
    chk({tag, "_wb_data"}, wb_data, exp);
    chk({tag, "_idle_req"}, req, 0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1;
    bubble();
    gnt = 0; rvalid = 0; rdata = 0;
    #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_req", req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_rw", wb_rw, 0);
    chk("rst_fault", fault, 0);
    #3 rst_n = 1;
    step();

    // ADD -> rd 5
    ex_valid = 1; ex_alu = 32'h10; ex_rd = 5;
    ex_rw = 1; ex_pc4 = 32'h44; ex_wbsel = 2'd2;
    step();
    chk("add_fwd", alu_mem, 32'h10);
    chk("add_stall", stall, 0);
    bubble();
    step();
    chk("add_wb_valid", wb_valid, 1);
    chk("add_wb_rd", wb_rd, 5);
    chk("add_wb_rw", wb_rw, 1);
    chk("add_wb_alu", wb_alu, 32'h10);
    chk("add_wb_pc4", wb_pc4, 32'h44);
    chk("add_wb_sel", wb_sel, 2);
    chk("add_stall2", stall, 0);

    // sb 0x103, gnt after 2 cycles
    ex_valid = 1; ex_alu = 32'h103;
    ex_rs2 = 32'h1234_56AB; ex_f3 = 3'b000;
    ex_mw = 1;
    step();
    bubble();
    chk("sb_req", req, 1);
    chk("sb_we", we, 1);
    chk("sb_addr", addr, 32'h100);
    chk("sb_be", be, 4'b1000);
    chk("sb_wdata", wdata, 32'hABAB_ABAB);
    chk("sb_stall1", stall, 1);
    step();
    chk("sb_stall2", stall, 1);
    chk("sb_addr2", addr, 32'h100);
    chk("sb_wdata2", wdata, 32'hABAB_ABAB);
    chk("sb_be2", be, 4'b1000);
    chk("sb_wb_bubble", wb_valid, 0);
    gnt = 1;
    #1;
    chk("sb_gnt_stall", stall, 0);
    chk("sb_gnt_req", req, 1);
    step();
    gnt = 0;
    chk("sb_done_req", req, 0);
    chk("sb_wb_valid", wb_valid, 1);
    chk("sb_wb_rw", wb_rw, 0);
    chk("sb_fault", fault, 0);

    // sh 0x102: upper lanes
    ex_valid = 1; ex_alu = 32'h102;
    ex_rs2 = 32'h0000_BEEF; ex_f3 = 3'b001;
    ex_mw = 1;
    step();
    bubble();
    chk("sh_be", be, 4'b1100);
    chk("sh_wdata", wdata, 32'hBEEF_BEEF);
    gnt = 1;
    step();
    gnt = 0;
    chk("sh_done_req", req, 0);

    // loads on lane 2 of 0x0080_0000
    do_load("lb", 3'b000, 32'h102,
            32'h0080_0000, 32'hFFFF_FF80, 2);
    do_load("lbu", 3'b100, 32'h102,
            32'h0080_0000, 32'h0000_0080, 0);
    do_load("lh", 3'b001, 32'h102,
            32'h0080_0000, 32'h0000_0080, 0);
    do_load("lhn", 3'b001, 32'h100,
            32'h1234_8001, 32'hFFFF_8001, 0);

    // misaligned lw
    set_load(3'b010, 32'h106);
    step();
    bubble();
    chk("lwmis_req", req, 0);
    chk("lwmis_stall", stall, 0);
    step();
    chk("lwmis_wb_valid", wb_valid, 1);
    chk("lwmis_fault", fault, 1);
    chk("lwmis_wb_rw", wb_rw, 0);

    // illegal funct3 load
    set_load(3'b011, 32'h100);
    step();
    bubble();
    chk("f3_req", req, 0);
    step();
    chk("f3_fault", fault, 1);
    chk("f3_wb_rw", wb_rw, 0);
    step();
    chk("f3_fault_clr", fault, 0);

    // sw then lw back-to-back, gnt held
    ex_valid = 1; ex_alu = 32'h200;
    ex_rs2 = 32'hDEAD_BEEF; ex_f3 = 3'b010;
    ex_mw = 1;
    gnt = 1;
    step();
    set_load(3'b010, 32'h204);
    #1;
    chk("b2b_sw_stall", stall, 0);
    chk("b2b_sw_we", we, 1);
    chk("b2b_sw_wdata", wdata, 32'hDEAD_BEEF);
    chk("b2b_sw_be", be, 4'b1111);
    step();
    bubble();
    chk("b2b_lw_req", req, 1);
    chk("b2b_lw_we", we, 0);
    chk("b2b_lw_addr", addr, 32'h204);
    chk("b2b_sw_wb", wb_valid, 1);
    step();
    chk("b2b_wait_req", req, 0);
    chk("b2b_wait_bubble", wb_valid, 0);
    rvalid = 1;
    rdata = 32'hCAFE_F00D;
    #1;
    chk("b2b_fwd", data_mem, 32'hCAFE_F00D);
    step();
    gnt = 0;
    rvalid = 0;
    chk("b2b_wb_valid", wb_valid, 1);
    chk("b2b_wb_data", wb_data, 32'hCAFE_F00D);
    chk("b2b_idle", req, 0);

    // reset while waiting for a load
    set_load(3'b010, 32'h300);
    gnt = 1;
    step();
    bubble();
    step();
    gnt = 0;
    chk("rw_wait_stall", stall, 1);
    rst_n = 0;
    #1;
    chk("rw_req", req, 0);
    chk("rw_stall", stall, 0);
    chk("rw_wb_valid", wb_valid, 0);
    #2 rst_n = 1;
    rvalid = 1;
    rdata = 32'h1111_1111;
    step();
    rvalid = 0;
    chk("rw_late_valid", wb_valid, 0);
    chk("rw_late_rw", wb_rw, 0);
    chk("rw_late_stall", stall, 0);
    ex_valid = 1; ex_alu = 32'h55; ex_rd = 3;
    ex_rw = 1;
    step();
    bubble();
    chk("rw_add_stall", stall, 0);
    chk("rw_add_fwd", alu_mem, 32'h55);
    step();
    chk("rw_add_wb", wb_valid, 1);
    chk("rw_add_alu", wb_alu, 32'h55);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
